byte_lane_packer: RTL and testbench

//   Packs an 8-bit byte stream into byte-enabled words for byte-enabled register sinks.

---
 rtl/byte_lane_packer.sv | 77 +++++++
 tb/tb_byte_lane_packer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/byte_lane_packer.sv
// Packs a byte-serial stream into LANES-wide words with per-lane write enables.
// A word is emitted when every lane is filled or when in_last flushes a partial word.
module byte_lane_packer #(
  parameter int LANES = 2
) (
  input  logic               clk,
  input  logic               areset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [LANES-1:0]   out_byteena,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {S_COLLECT, S_HOLD} state_t;

  state_t               r_state, w_state_nxt;
  logic [KW-1:0]        r_k, w_k_nxt, w_lane;
  logic [8*LANES-1:0]   r_data, w_data_nxt;
  logic [LANES-1:0]     r_be, w_be_nxt;
  logic                 w_in_fire, w_out_fire;

  assign out_valid   = (r_state == S_HOLD);
  assign out_data    = r_data;
  assign out_byteena = r_be;
  assign in_ready    = !out_valid || out_ready;
  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state <= S_COLLECT;
      r_k     <= '0;
      r_data  <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_data  <= w_data_nxt;
      r_be    <= w_be_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_data_nxt  = r_data;
    w_be_nxt    = r_be;
    w_lane      = r_k;

    // Retiring word: start a clean word so unwritten lanes read as zero.
    if (w_out_fire) begin
      w_state_nxt = S_COLLECT;
      w_k_nxt     = '0;
      w_data_nxt  = '0;
      w_be_nxt    = '0;
      w_lane      = '0;
    end

    if (w_in_fire) begin
      w_data_nxt[{w_lane, 3'b000} +: 8] = in_data;
      w_be_nxt[w_lane]                  = 1'b1;
      if ((w_lane == KW'(LANES - 1)) || in_last) begin
        w_state_nxt = S_HOLD;
        w_k_nxt     = '0;
      end else begin
        w_k_nxt = w_lane + KW'(1);
      end
    end
  end

endmodule

// File: tb/tb_byte_lane_packer.sv
// Directed and randomized checks of byte_lane_packer with LANES=2.
module tb_byte_lane_packer;

  logic        clk = 1'b0;
  logic        areset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_byteena;
  logic        out_valid;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  byte_q[$];
  logic [17:0] word_q[$];

  byte_lane_packer #(.LANES(2)) dut (
    .clk         (clk),
    .areset      (areset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_byteena (out_byteena),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic rand_cycle(input bit drain);
    logic        w_in_fire;
    logic [17:0] w_exp;
    if (drain) begin
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
    end else begin
      in_valid  = 1'($urandom_range(0, 1));
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
    end
    #1;
    check("rnd_in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    if (out_valid) check("rnd_nonempty", 32'(out_byteena == 2'b00), 32'd0);
    if (out_valid && out_ready) begin
      if (word_q.size() == 0) begin
        check("rnd_unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        w_exp = word_q.pop_front();
        check("rnd_data", 32'(out_data), 32'(w_exp[15:0]));
        check("rnd_be", 32'(out_byteena), 32'(w_exp[17:16]));
      end
    end
    w_in_fire = in_valid && in_ready;
    if (w_in_fire) begin
      byte_q.push_back(in_data);
      if (byte_q.size() == 2)
        word_q.push_back({2'b11, byte_q[1], byte_q[0]});
      else if (in_last)
        word_q.push_back({2'b01, 8'h00, byte_q[0]});
      if (byte_q.size() == 2 || in_last) byte_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    areset    = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    #1;
    // Test 1: reset values, then asynchronous clear of a held word.
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_byteena", 32'(out_byteena), 32'd0);
    @(posedge clk); #1;
    send(8'h5A, 1'b1);
    check("pre_async_valid", 32'(out_valid), 32'd1);
    #2 areset = 1'b1;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_out_data", 32'(out_data), 32'd0);
    check("async_byteena", 32'(out_byteena), 32'd0);
    areset = 1'b0;
    #1;
    check("async_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Test 2: full word.
    out_ready = 1'b1;
    send(8'hCD, 1'b0);
    check("full_not_yet", 32'(out_valid), 32'd0);
    send(8'hAB, 1'b0);
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_data", 32'(out_data), 32'hABCD);
    check("full_be", 32'(out_byteena), 32'h3);
    @(posedge clk); #1;
    check("full_one_cycle", 32'(out_valid), 32'd0);

    // Test 3: partial flush, next byte restarts at lane 0.
    send(8'h5A, 1'b1);
    check("part_valid", 32'(out_valid), 32'd1);
    check("part_data", 32'(out_data), 32'h005A);
    check("part_be", 32'(out_byteena), 32'h1);
    @(posedge clk); #1;
    send(8'h11, 1'b0);
    check("part_next_collect", 32'(out_valid), 32'd0);
    send(8'h22, 1'b1);
    check("part_next_data", 32'(out_data), 32'h2211);
    check("part_next_be", 32'(out_byteena), 32'h3);
    @(posedge clk); #1;

    // Test 4: backpressure, then retire and accept in the same cycle.
    out_ready = 1'b0;
    send(8'h34, 1'b0);
    send(8'h12, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h99;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h1234);
      check("bp_be", 32'(out_byteena), 32'h3);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_data   = 8'h77;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_collect", 32'(out_valid), 32'd0);
    send(8'h88, 1'b0);
    check("bp_new_data", 32'(out_data), 32'h8877);
    check("bp_new_be", 32'(out_byteena), 32'h3);
    @(posedge clk); #1;

    // Test 5: reset mid-word discards the partial byte.
    send(8'hEE, 1'b0);
    #2 areset = 1'b1;
    #1 areset = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    check("midrst_data", 32'(out_data), 32'h0201);
    check("midrst_be", 32'(out_byteena), 32'h3);
    @(posedge clk); #1;

    // Test 6: random traffic against the queue model.
    byte_q.delete();
    word_q.delete();
    for (int i = 0; i < 400; i++) rand_cycle(1'b0);
    for (int i = 0; i < 4; i++) rand_cycle(1'b1);
    check("rnd_drained", 32'(word_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
